// File: rtl/pp_pkg.sv
// Shared types and default sizing for the partial-product row accumulator.
package pp_pkg;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned PROD_W = 2 * WIDTH;

  // Counter width for a given operand width; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int unsigned CNT_W = cnt_w(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } acc_state_t;

endpackage

// File: rtl/pp_row_align.sv
// Shifts a partial-product row to its column position in the product.
// Define PP_ROW_ACCUMULATOR_TRUNC_EN to drop every column below WIDTH-1.
module pp_row_align #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 3
) (
  input  logic [WIDTH-1:0]   row_i,
  input  logic [CNT_W-1:0]   index_i,
  output logic [2*WIDTH-1:0] aligned_o
);

  logic [WIDTH-1:0] masked;

  always_comb begin
    masked = row_i;
`ifdef PP_ROW_ACCUMULATOR_TRUNC_EN
    // Bit j of row k lands in column k+j; columns below WIDTH-1 are discarded.
    for (int unsigned j = 0; j < WIDTH; j++) begin
      if ((int'(index_i) + int'(j)) < (int'(WIDTH) - 1)) begin
        masked[j] = 1'b0;
      end
    end
`endif
    aligned_o = {{WIDTH{1'b0}}, masked} << index_i;
  end

endmodule

// File: rtl/pp_row_accumulator.sv
// Sequential partial-product reducer: one row per handshake, product after WIDTH rows.
// Optional column truncation via PP_ROW_ACCUMULATOR_TRUNC_EN (inside pp_row_align).
module pp_row_accumulator #(
  parameter int unsigned WIDTH = pp_pkg::WIDTH,
  localparam int unsigned CW   = pp_pkg::cnt_w(WIDTH),
  localparam int unsigned PW   = 2 * WIDTH
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [WIDTH-1:0] in_row,
  output logic [CW-1:0]   row_idx,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PW-1:0]   out_product,
  output logic            busy
);

  import pp_pkg::*;

  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  acc_state_t    state_q, state_d;
  logic [PW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] aligned;
  logic [PW:0]   sum;

  pp_row_align #(
    .WIDTH (WIDTH),
    .CNT_W (CW)
  ) u_align (
    .row_i     (in_row),
    .index_i   (cnt_q),
    .aligned_o (aligned)
  );

  assign sum = {1'b0, acc_q} + {1'b0, aligned};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            acc_d = aligned;
            if (WIDTH == 1) begin
              state_d = DONE;
              cnt_d   = LAST_IDX;
            end else begin
              state_d = ACCUM;
              cnt_d   = CW'(1);
            end
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc_d = sum[PW-1:0];
            // Counter parks on the last index in DONE instead of wrapping.
            if (cnt_q == LAST_IDX) begin
              state_d = DONE;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready    = (state_q != DONE);
  assign out_valid   = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign row_idx     = cnt_q;
  assign out_product = (state_q == DONE) ? acc_q : '0;

  // The product of two WIDTH-bit operands always fits; a carry means corrupted state.
  a_no_carry: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == ACCUM && in_valid && !flush) |-> !sum[PW]);

endmodule

// File: tb/tb_pp_row_accumulator.sv
// Randomized self-checking bench for pp_row_accumulator (WIDTH=8).
module tb_pp_row_accumulator;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_row = '0;
  logic [2:0]   row_idx;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [2*W-1:0] out_product;
  logic         busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  pp_row_accumulator #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_row      (in_row),
    .row_idx     (row_idx),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_product (out_product),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Reference: schoolbook product, optionally keeping only columns >= W-1.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    int unsigned s;
    s = 0;
    for (int k = 0; k < W; k++)
      for (int j = 0; j < W; j++) begin
`ifdef PP_ROW_ACCUMULATOR_TRUNC_EN
        if (j + k >= W - 1)
`endif
          s += (((x >> j) & 1) * ((y >> k) & 1)) << (j + k);
      end
    return s[2*W-1:0];
  endfunction

  task automatic check_idle(input string name);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || row_idx !== 3'd0) begin
      errors++;
      $display("FAIL %s: out_valid=%b busy=%b in_ready=%b row_idx=%0d, required 0 0 1 0",
               name, out_valid, busy, in_ready, row_idx);
    end
  endtask

  // Feeds rows k=0..start_k-1 of x*y back to back (used to reach mid-ACCUM).
  task automatic feed_rows(input logic [W-1:0] x, input logic [W-1:0] y, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_row   = x & {W{y[k]}};
    end
  endtask

  task automatic run_product(input logic [W-1:0] x, input logic [W-1:0] y,
                             input int gap_pct, input int stall, input bit chk_lat,
                             input string name);
    logic [2*W-1:0] exp;
    int k;
    int first;
    exp   = model(x, y);
    k     = 0;
    first = -1;
    while (k < W) begin
      @(negedge clk);
      checks++;
      if (row_idx !== 3'(k) || out_valid !== 1'b0 || busy !== (k != 0) || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL %s row%0d: row_idx=%0d out_valid=%b busy=%b in_ready=%b, required %0d 0 %b 1",
                 name, k, row_idx, out_valid, busy, in_ready, k, k != 0);
      end
      if ($urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        in_row   = W'($urandom);
      end else begin
        in_valid = 1'b1;
        in_row   = x & {W{y[k]}};
        if (first < 0) first = cyc;
        k++;
      end
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s latency: out_valid=%b after last row, required 1", name, out_valid);
    end
    if (chk_lat) begin
      // Back-to-back: out_valid in the (W+1)th cycle counting the first handshake cycle.
      checks++;
      if (cyc - first !== W) begin
        errors++;
        $display("FAIL %s cycles: got %0d, required %0d", name, cyc - first, W);
      end
    end
    for (int s = 0; s <= stall; s++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 || out_product !== exp) begin
        errors++;
        $display("FAIL %s done%0d: out_valid=%b in_ready=%b busy=%b product=%h, required 1 0 1 %h",
                 name, s, out_valid, in_ready, busy, out_product, exp);
      end
      in_valid  = 1'b1;
      in_row    = W'($urandom);
      out_ready = (s == stall);
      if (s < stall) @(negedge clk);
    end
    @(negedge clk);
    check_idle({name, " release"});
    out_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (out_product !== '0) begin
      errors++;
      $display("FAIL reset product: got %h, required 0", out_product);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("reset");
  endtask

  task automatic test_back_to_back;
    run_product(8'h0D, 8'h0B, 0, 0, 1'b1, "b2b_0D_0B");
  endtask

  task automatic test_gaps;
    run_product(8'hFF, 8'hFF, 40, 0, 1'b0, "gaps_FF_FF");
    run_product(8'h01, 8'h01, 20, 0, 1'b0, "gaps_01_01");
  endtask

  task automatic test_backpressure;
    run_product(8'hA7, 8'h5C, 0, 5, 1'b0, "backpressure");
  endtask

  task automatic test_flush;
    feed_rows(8'h6B, 8'hD3, 4);
    @(negedge clk);
    in_valid = 1'b1;
    in_row   = 8'h6B;
    flush    = 1'b1;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    check_idle("flush_accum");
    run_product(8'h03, 8'h05, 0, 0, 1'b1, "after_flush");
    // Flush in DONE, together with out_ready, then flush in IDLE with a row offered.
    feed_rows(8'h33, 8'hF0, W);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL flush_done pre: out_valid=%b, required 1", out_valid);
    end
    flush     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_row    = 8'hFF;
    check_idle("flush_done");
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    check_idle("flush_idle");
    run_product(8'hC9, 8'h27, 0, 1, 1'b0, "after_flush_idle");
  endtask

  task automatic test_reset_mid;
    feed_rows(8'h5A, 8'hFF, 3);
    @(negedge clk);
    in_valid = 1'b1;
    in_row   = 8'h5A;
    rst_n    = 1'b0;
    #1;
    check_idle("reset_mid");
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    run_product(8'h80, 8'h02, 0, 0, 1'b1, "after_reset");
  endtask

  task automatic test_random;
    for (int i = 0; i < 20; i++) begin
      run_product(W'($urandom), W'($urandom), 30, $urandom_range(3), 1'b0, "random");
    end
  endtask

  initial begin
    test_reset;
    test_back_to_back;
    test_gaps;
    test_backpressure;
    test_flush;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pp_row_accumulator.md
Name: pp_row_accumulator

Overview:
- Sequential consumer of partial-product rows: accepts one WIDTH-bit row per handshake, aligns it by row index, accumulates, and emits the 2*WIDTH-bit product.
- Sits downstream of the partial-product generators. Serves as the low-area reduction stage alternative to the Dadda/Wallace trees in the multiplier family.
- Producer drives row k = x & {WIDTH{y[k]}}. The row index comes from this block.

Parameters:
- WIDTH, 8, operand width; rows per product = WIDTH; product width = 2*WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous abort; discards the current product.
- in_valid  input  1  row offered.
- in_ready  output  1  block accepts row this cycle.
- in_row  input  WIDTH  partial-product row; bit j has weight 2^(j+row_idx).
- row_idx  output  $clog2(WIDTH)  index of the next row expected (0..WIDTH-1).
- out_valid  output  1  product valid.
- out_ready  input  1  consumer takes product.
- out_product  output  2*WIDTH  accumulated product.
- busy  output  1  high in ACCUM or DONE.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, acc=0, cnt=0, out_valid=0, out_product=0, busy=0, row_idx=0.
  - in_ready=1 once reset is released.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready=1, busy=0.
  - On in_valid: acc <= aligned(row,0), cnt <= 1, go to ACCUM.
  - Exception WIDTH==1: go directly to DONE.
- ACCUM:
  - in_ready=1, busy=1.
  - On in_valid: acc <= acc + (aligned(row,cnt) << cnt), cnt <= cnt+1.
  - If cnt==WIDTH-1 the row is the last one: go to DONE.
  - Without in_valid, state and acc hold. Gaps are allowed.
- DONE:
  - out_valid=1, in_ready=0, busy=1, out_product=acc, stable.
  - On out_ready: go to IDLE, acc <= 0, cnt <= 0.
  - No new row is accepted in the same cycle as the output handshake.
- Latency: out_valid rises the cycle after the last row handshake. Minimum WIDTH+1 cycles per product; throughput one product per WIDTH+1 cycles.
- Arithmetic:
  - acc is 2*WIDTH bits, unsigned.
  - Shifted row is zero-extended.
  - Overflow is impossible, since the max sum is (2^WIDTH-1)^2.
  - No modular wrap permitted; assert on carry-out of bit 2*WIDTH-1.
- row_idx = cnt in IDLE/ACCUM. Value in DONE is don't-care; it is held at WIDTH-1.
- flush:
  - Highest priority except reset.
  - Next cycle: state=IDLE, acc=0, cnt=0, out_valid=0.
  - Any row or output handshake in the flush cycle is discarded.
  - Flush in IDLE has no effect.
- Reset mid-operation: immediate return to the reset values; the partial accumulation is lost.
- in_row is sampled only on a handshake. Changes while in_ready=0 are ignored.

Optional Feature:
- Macro: PP_ROW_ACCUMULATOR_TRUNC_EN.
- When defined:
  - aligned(row,k) masks bit j to 0 whenever k+j < WIDTH-1.
  - This gives a column-truncated approximate product: only columns ≥ WIDTH-1 are kept.
  - out_product bits [WIDTH-2:0] are therefore always 0.
- When undefined: aligned(row,k)=row, giving an exact product.
- Handshake and timing are identical in both builds.

Decomposition:
- Package pp_pkg:
  - WIDTH default and PROD_W=2*WIDTH localparam.
  - typedef enum logic[1:0] {IDLE, ACCUM, DONE} acc_state_t.
  - CNT_W = $clog2(WIDTH) constant.
- Sub-module pp_row_align (combinational):
  - Inputs: row, index. Output: the 2*WIDTH shifted, optionally truncation-masked row.
  - The truncation macro is confined to this sub-module.
- FSM, counter and accumulator register stay in pp_row_accumulator.

Test Plan:
- WIDTH=8, x=0x0D, y=0x0B, rows fed back-to-back → out_valid 9 cycles after first handshake, out_product=0x008F. row_idx steps 0..7.
- x=0xFF, y=0xFF with random in_valid gaps → out_product=0xFE01. acc holds during gaps.
- Backpressure: out_ready low for 5 cycles in DONE, with in_valid held high → product stable, in_ready=0, no row consumed. On out_ready=1, IDLE next cycle.
- flush asserted on the row-4 handshake → IDLE next cycle, row 4 discarded. Next operation 0x03*0x05 → 0x000F.
- rst_n pulled low mid-ACCUM (row 3) → out_valid=0, busy=0 immediately. Subsequent product 0x80*0x02 → 0x0100.
- PP_ROW_ACCUMULATOR_TRUNC_EN defined, x=y=0xFF → out_product=0xFB00. x=0x01, y=0x01 → 0x0000.
